vga_frame_scanner: RTL

// - Consumer of the CPU's 256x256 8-bit pixel RAM read port (port b). Generates 640x480@60 VGA timing.
// - Issues RAM read addresses. Realigns returned pixels, with their read latency, to the sync pipeline.
// - Drives grayscale RGB, centred in the visible area; background outside the image window.
// - Replaces the free-running pixel address counter: addresses follow the scan, not a bare counter.

---
 rtl/vga_frame_scanner.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_frame_scanner.sv
// VGA 640x480@60 scanner for a 256x256 8-bit pixel RAM; pixels realigned to sync by RD_LAT.
// Define VGA_BORDER_EN to draw a white 1-pixel outline just outside the image window.
module vga_frame_scanner #(
   parameter int         RD_LAT   = 1,
   parameter int         IMG_X0   = 192,
   parameter int         IMG_Y0   = 112,
   parameter logic [7:0] BG_LEVEL = 8'd0,
   parameter int         H_VIS    = 640,
   parameter int         H_FP     = 16,
   parameter int         H_SYNC   = 96,
   parameter int         H_BP     = 48,
   parameter int         V_VIS    = 480,
   parameter int         V_FP     = 10,
   parameter int         V_SYNC   = 2,
   parameter int         V_BP     = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic        enable,
   input  logic [7:0]  pixel_in,
   output logic [15:0] pixel_addr,
   output logic        hsync,
   output logic        vsync,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        blank_n,
   output logic        frame_start
);
   localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

   typedef enum logic {IDLE, SCAN} state_t;
   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
      logic win;
`ifdef VGA_BORDER_EN
      logic brd;
`endif
   } stage_t;
   localparam int     STG_W    = $bits(stage_t);
   localparam stage_t STG_IDLE = stage_t'({2'b11, {(STG_W-2){1'b0}}});

   state_t                 state_q, state_d;
   logic [9:0]             h_q, h_d, v_q, v_d;
   logic [15:0]            addr_q, addr_d;
   logic                   fs_q, fs_d, hs_q, hs_d, vs_q, vs_d, bn_q, bn_d;
   logic [7:0]             rgb_q, rgb_d;
   stage_t [RD_LAT-1:0]    pipe_q, pipe_d;
   stage_t                 stg_in, tail;

   function automatic logic in_win(logic [9:0] h, logic [9:0] v);
      return h >= 10'(IMG_X0) && h < 10'(IMG_X0 + 256) &&
             v >= 10'(IMG_Y0) && v < 10'(IMG_Y0 + 256);
   endfunction

`ifdef VGA_BORDER_EN
   function automatic logic on_border(logic [9:0] h, logic [9:0] v);
      logic x_ext, y_ext;
      x_ext = h >= 10'(IMG_X0 - 1) && h <= 10'(IMG_X0 + 256);
      y_ext = v >= 10'(IMG_Y0 - 1) && v <= 10'(IMG_Y0 + 256);
      return (x_ext && (v == 10'(IMG_Y0 - 1) || v == 10'(IMG_Y0 + 256))) ||
             (y_ext && (h == 10'(IMG_X0 - 1) || h == 10'(IMG_X0 + 256)));
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      addr_d  = addr_q;
      fs_d    = fs_q;
      pipe_d  = pipe_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      bn_d    = bn_q;
      rgb_d   = rgb_q;
      tail    = pipe_q[RD_LAT-1];

      // Flags for the current counter position; IDLE feeds blanked, inactive sync.
      stg_in = STG_IDLE;
      if (state_q == SCAN) begin
         stg_in.hs  = !(h_q >= 10'(H_VIS + H_FP) && h_q < 10'(H_VIS + H_FP + H_SYNC));
         stg_in.vs  = !(v_q >= 10'(V_VIS + V_FP) && v_q < 10'(V_VIS + V_FP + V_SYNC));
         stg_in.act = h_q < 10'(H_VIS) && v_q < 10'(V_VIS);
         stg_in.win = in_win(h_q, v_q);
`ifdef VGA_BORDER_EN
         stg_in.brd = on_border(h_q, v_q);
`endif
      end

      if (pix_en) begin
         fs_d = (state_q == SCAN) && h_q == 10'd0 && v_q == 10'd0;
         if (state_q == IDLE) begin
            h_d = '0;
            v_d = '0;
            if (enable) state_d = SCAN;
         end else if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d = '0;
               if (!enable) state_d = IDLE;
            end else begin
               v_d = v_q + 10'd1;
            end
         end else begin
            h_d = h_q + 10'd1;
         end

         // Address tracks the new counter value so RAM data returns RD_LAT ticks later,
         // exactly when the matching flags leave the last pipeline stage.
         if (state_d == IDLE)
            addr_d = '0;
         else if (in_win(h_d, v_d))
            addr_d = {8'(v_d - 10'(IMG_Y0)), 8'(h_d - 10'(IMG_X0))};

         pipe_d[0] = stg_in;
         for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

         hs_d = tail.hs;
         vs_d = tail.vs;
         bn_d = tail.act;
         if (!tail.act)
            rgb_d = 8'h00;
         else if (tail.win)
            rgb_d = pixel_in;
`ifdef VGA_BORDER_EN
         else if (tail.brd)
            rgb_d = 8'hFF;
`endif
         else
            rgb_d = BG_LEVEL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         h_q     <= '0;
         v_q     <= '0;
         addr_q  <= '0;
         fs_q    <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         bn_q    <= 1'b0;
         rgb_q   <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= STG_IDLE;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         addr_q  <= addr_d;
         fs_q    <= fs_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         bn_q    <= bn_d;
         rgb_q   <= rgb_d;
         pipe_q  <= pipe_d;
      end
   end

   assign pixel_addr  = addr_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign blank_n     = bn_q;
   assign vga_r       = rgb_q;
   assign vga_g       = rgb_q;
   assign vga_b       = rgb_q;
   assign frame_start = fs_q;

endmodule
